// File: rtl/segment_register_bank.sv
// Bank of NUM_SEGS segment registers with two combinational read ports and a
// LIFO shadow stack that saves/restores the whole bank in one cycle.
module segment_register_bank #(
  parameter int               WIDTH       = 16,
  parameter int               NUM_SEGS    = 4,
  parameter int               SEL_W       = 2,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic [SEL_W-1:0]             load_sel,
  input  logic [WIDTH-1:0]             load_data,
  input  logic [SEL_W-1:0]             rd_sel_a,
  input  logic [SEL_W-1:0]             rd_sel_b,
  output logic [WIDTH-1:0]             rd_data_a,
  output logic [WIDTH-1:0]             rd_data_b,
  output logic [WIDTH-1:0]             isr_data_out,
  input  logic                         save,
  input  logic                         restore,
  output logic [$clog2(DEPTH+1)-1:0]   depth_count,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] bank_q   [NUM_SEGS];
  logic [WIDTH-1:0] bank_d   [NUM_SEGS];
  logic [WIDTH-1:0] shadow_q [DEPTH][NUM_SEGS];

  logic [CNT_W-1:0] depth_count_q, depth_count_d;
  logic             stack_full_q, stack_full_d;
  logic             stack_empty_q, stack_empty_d;
  logic             err_q, err_d;

  logic             load_in_range;
  logic             load_ok;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_comb begin
    load_in_range = (32'(load_sel) < NUM_SEGS);
    push          = save && !restore && !stack_full_q;
    pop           = restore && !save && !stack_empty_q;
    wr_ptr        = PTR_W'(depth_count_q);
    rd_ptr        = PTR_W'(depth_count_q - CNT_W'(1));
    // A lone restore owns the bank this cycle, even when it fails on an empty stack.
    load_ok       = load_en && load_in_range && !(restore && !save);

    for (int i = 0; i < NUM_SEGS; i++) begin
      bank_d[i] = bank_q[i];
      if (pop) begin
        bank_d[i] = shadow_q[rd_ptr][i];
      end else if (load_ok && (32'(load_sel) == 32'(i))) begin
        bank_d[i] = load_data;
      end
    end

    depth_count_d = depth_count_q;
    if (push) begin
      depth_count_d = depth_count_q + CNT_W'(1);
    end else if (pop) begin
      depth_count_d = depth_count_q - CNT_W'(1);
    end
    stack_full_d  = (32'(depth_count_d) == DEPTH);
    stack_empty_d = (depth_count_d == '0);

    err_d = err_q;
    if (load_en && !load_in_range)               err_d = 1'b1;
    if (save && restore)                         err_d = 1'b1;
    if (save && !restore && stack_full_q)        err_d = 1'b1;
    if (restore && !save && stack_empty_q)       err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        bank_q[i] <= RESET_VALUE;
      end
      depth_count_q <= '0;
      stack_full_q  <= 1'b0;
      stack_empty_q <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        bank_q[i] <= bank_d[i];
      end
      depth_count_q <= depth_count_d;
      stack_full_q  <= stack_full_d;
      stack_empty_q <= stack_empty_d;
      err_q         <= err_d;
    end
  end

  // Shadow contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        shadow_q[wr_ptr][i] <= bank_q[i];
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (32'(rd_sel_a) < NUM_SEGS) rd_data_a = bank_q[rd_sel_a];
    if (32'(rd_sel_b) < NUM_SEGS) rd_data_b = bank_q[rd_sel_b];
  end

  assign isr_data_out = bank_q[0];
  assign depth_count  = depth_count_q;
  assign stack_full   = stack_full_q;
  assign stack_empty  = stack_empty_q;
  assign err          = err_q;

endmodule

// File: doc/segment_register_bank.md
# segment_register_bank

Parametrised successor to the single instruction segment register: a bank of NUM_SEGS segment registers (code, data, stack, extra, …) with per-register load, two combinational read ports, and a LIFO shadow stack that saves and restores the whole bank in one cycle for interrupt entry and exit. The bank sits between the control unit and the address generator. The control unit drives loads and save/restore. The address generator reads the selected segments every cycle.

## Interface
- WIDTH, 16: segment register width in bits
- NUM_SEGS, 4: number of segment registers, at least 2; index 0 is the instruction segment
- SEL_W, 2: select width, equal to clog2(NUM_SEGS)
- DEPTH, 4: shadow-stack depth in whole-bank contexts, at least 1
- RESET_VALUE, 0: reset value of every segment register

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- load_en  in  1  write load_data into register load_sel at the next edge
- load_sel  in  SEL_W  target register; values at or above NUM_SEGS are ignored
- load_data  in  WIDTH  data to write
- rd_sel_a, rd_sel_b  in  SEL_W  read selects
- rd_data_a, rd_data_b  out  WIDTH  combinational reads of the current register contents; out-of-range select returns 0
- isr_data_out  out  WIDTH  always register 0
- save  in  1  push the entire bank onto the shadow stack
- restore  in  1  pop the top context back into the bank
- depth_count  out  clog2(DEPTH+1)  number of saved contexts
- stack_full  out  1  depth_count == DEPTH
- stack_empty  out  1  depth_count == 0
- err  out  1  sticky error flag; cleared only by reset

## Operation
- Reset, asynchronous:
  - all registers = RESET_VALUE
  - depth_count = 0, stack_empty = 1, stack_full = 0, err = 0
  - shadow storage contents are don't-care
- Load:
  - load_en with an in-range load_sel updates that register at the edge
  - an out-of-range load_sel is a no-op and sets err
- Save (save=1, restore=0):
  - not full: the current bank values (pre-edge) are written to slot depth_count, and depth_count increments
  - full: no push, depth_count unchanged, err set
- Restore (restore=1, save=0):
  - not empty: the bank is loaded from slot depth_count-1, and depth_count decrements
  - empty: bank and count unchanged, err set
- save and restore asserted together: no-op on the stack and bank, err set. Any load_en in that cycle still applies.
- Priority when load coincides:
  - save + load_en: the pushed context holds the pre-load values, and the load also takes effect. This matches interrupt entry, which saves the old CS and loads the vector CS in the same cycle.
  - restore + load_en: restore wins for every register, and the load is discarded silently (no err).
- The shadow stack is a pure LIFO with no wrap-around. Slots are indexed 0..DEPTH-1 by depth_count.

## Timing
- All register updates occur on the rising clk edge. Loaded or restored values are visible on the read ports and isr_data_out in the cycle after the edge, with zero combinational latency after that.
- Read ports have no write-through: a read of a register being loaded returns the old value until the edge.
- depth_count, stack_full, stack_empty and err are registered and update at the same edge as the operation that changes them.
- Reset asserted mid-operation:
  - all outputs reach their reset values without waiting for a clock edge
  - any save/restore in flight is lost
  - operation resumes on the first edge after reset deasserts
- Back-to-back save/restore on consecutive cycles is fully supported, at one operation per cycle.

## Test plan
- Reset: assert reset for 10 ns → all rd_data = 0, isr_data_out = 0, stack_empty = 1, err = 0. Load 16'hABCD into seg 0, then assert reset between edges → isr_data_out returns to 0 immediately.
- Load and hold:
  - load seg0 = 16'hABCD, then deassert load_en with load_data = 16'h1234 → isr_data_out stays ABCD
  - load seg2 = 16'h5678 → rd_data_a (sel 2) = 5678 one cycle later, and the other registers are unchanged
- Save with concurrent load: bank = {1111, 2222, 3333, 4444}; save + load seg0 = 16'h8000 → seg0 = 8000, depth_count = 1. Then restore → bank = {1111, 2222, 3333, 4444}, stack_empty = 1.
- Nesting: 4 saves with distinct bank contents → stack_full = 1. A 5th save → err = 1 and depth_count stays 4. Then 4 restores → contexts return in reverse order.
- Underflow and conflict:
  - restore when empty → bank unchanged, err = 1
  - after reset, save + restore together with load seg1 = 16'h00FF → depth_count = 0, seg1 = 00FF, err = 1
- Restore with concurrent load: after one save of bank = {AAAA, …}, restore + load seg0 = 16'h5555 → seg0 = AAAA, err = 0.
